// File: rtl/sevenseg_pkg.sv
// Purpose: shared types and the hex-to-segment decode for scanned 7-segment displays.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package sevenseg_pkg;

  // Segment vector {a,b,c,d,e,f,g}, active high.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Active-high segment pattern for one hex nibble.
  function automatic seg_t hex2seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h73;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h0D;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Purpose: free-running slot prescaler; cnt counts 0..DIV_CNT-1, tick marks the last count.
// Latency: tick is combinational from the registered count (high during cnt==DIV_CNT-1).
// Backpressure: none; runs every clock cycle.
// Ports: clk/rst (async active-high) in; cnt (slot position) and tick (slot end) out.
module scan_prescaler #(
  parameter int DIV_CNT = 100000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [$clog2(DIV_CNT)-1:0] cnt,
  output logic                       tick
);

  localparam int CNT_W = $clog2(DIV_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_CNT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign tick = w_tick;

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Purpose: time-multiplexed common-anode 7-segment driver with per-frame snapshot,
//          anti-ghost guard, per-digit enable, decimal points and leading-zero blanking.
// Latency: outputs registered, 1 cycle after the (cnt, idx) slot position. Backpressure: none.
// Ports: clk/rst in; data (hex nibbles, digit 0 rightmost), dp, digit_en, lz_en in;
//        segs_l/dp_l/an_l active-low display pins out; frame_done 1-cycle pulse per frame out.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS      = 8,
  parameter int DIV_CNT      = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     digit_en,
  input  logic                   lz_en,
  output logic [6:0]             segs_l,
  output logic                   dp_l,
  output logic [NDIGITS-1:0]     an_l,
  output logic                   frame_done
);

  localparam int CNT_W = $clog2(DIV_CNT);
  localparam int IDX_W = $clog2(NDIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

  logic [CNT_W-1:0]     w_cnt;
  logic                 w_tick;
  logic [IDX_W-1:0]     r_idx;

  logic [4*NDIGITS-1:0] r_data;
  logic [NDIGITS-1:0]   r_dp;
  logic [NDIGITS-1:0]   r_en;
  logic                 r_lz;

  logic                 w_snap;
  logic [4*NDIGITS-1:0] w_data;
  logic [NDIGITS-1:0]   w_dp;
  logic [NDIGITS-1:0]   w_en;
  logic                 w_lz;
  logic [3:0]           w_nib [NDIGITS];
  logic [NDIGITS-1:0]   w_lz_blank;
  logic [NDIGITS-1:0]   w_on;
  logic                 w_guard_ok;
  logic [NDIGITS-1:0]   w_an_next;

  seg_t                 r_segs_l;
  logic                 r_dp_l;
  logic [NDIGITS-1:0]   r_an_l;
  logic                 r_frame_done;

  scan_prescaler #(.DIV_CNT(DIV_CNT)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .cnt  (w_cnt),
    .tick (w_tick)
  );

  // Digit index advances at each slot end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Frame start: capture the display inputs for the whole frame.
  assign w_snap = (w_cnt == '0) && (r_idx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_dp   <= '0;
      r_en   <= '0;
      r_lz   <= 1'b0;
    end else if (w_snap) begin
      r_data <= data;
      r_dp   <= dp;
      r_en   <= digit_en;
      r_lz   <= lz_en;
    end
  end

  // On the snapshot cycle the shadow regs still hold the old frame, so the
  // first output of a frame is decoded straight from the inputs being captured.
  assign w_data = w_snap ? data     : r_data;
  assign w_dp   = w_snap ? dp       : r_dp;
  assign w_en   = w_snap ? digit_en : r_en;
  assign w_lz   = w_snap ? lz_en    : r_lz;

  always_comb begin
    for (int i = 0; i < NDIGITS; i++) begin
      w_nib[i] = w_data[4*i +: 4];
    end
  end

  // Leading-zero chain, scanned from the most significant digit down:
  // a digit is blank while it and every digit above it are zero.
  always_comb begin
    logic w_zero_run;
    w_zero_run = 1'b1;
    w_lz_blank = '0;
    w_on       = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      w_zero_run    = w_zero_run && (w_nib[i] == 4'h0);
      w_lz_blank[i] = w_lz && (i != 0) && w_zero_run;
      w_on[i]       = w_en[i] && !w_lz_blank[i];
    end
  end

  // Anti-ghost guard: anodes stay off for the first GUARD_CYCLES of each slot.
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign w_guard_ok = 1'b1;
    end else begin : g_guard
      localparam logic [CNT_W-1:0] GUARD_V = CNT_W'(GUARD_CYCLES);
      assign w_guard_ok = (w_cnt >= GUARD_V);
    end
  endgenerate

  always_comb begin
    w_an_next = '1;
    if (w_on[r_idx] && w_guard_ok) begin
      w_an_next[r_idx] = 1'b0;
    end
  end

  // Async reset on the output regs blanks the display the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_segs_l     <= ~SEG_BLANK;
      r_dp_l       <= 1'b1;
      r_an_l       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_segs_l     <= ~hex2seg(w_nib[r_idx]);
      r_dp_l       <= ~w_dp[r_idx];
      r_an_l       <= w_an_next;
      r_frame_done <= w_tick && (r_idx == IDX_LAST);
    end
  end

  assign segs_l     = r_segs_l;
  assign dp_l       = r_dp_l;
  assign an_l       = r_an_l;
  assign frame_done = r_frame_done;

endmodule
